// File: rtl/counter_pkg.sv
// Shared constants and elaboration-time helpers for the up/down toggle counter.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // A modulus is usable when it is at least 2 and every legal count fits in WIDTH bits.
  function automatic bit mod_legal(input int width, input int modulus);
    return (width >= 1) && (modulus >= 2) && (clog2(modulus) <= width);
  endfunction

endpackage

// File: rtl/tff_bit.sv
// Single toggle-flop bit cell: q inverts on each rising clk edge where t is high.
module tff_bit (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/mod_updown_toggle_counter.sv
// Modulo-MOD up/down counter: computes a per-bit toggle vector that drives a bank
// of toggle-flop cells, with clear, parallel load, cascade tc and wrap/load_err pulses.
module mod_updown_toggle_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  generate
    if (!mod_legal(WIDTH, MOD)) begin : g_bad_mod
      $error("mod_updown_toggle_counter: MOD=%0d is not legal for WIDTH=%0d", MOD, WIDTH);
    end
  endgenerate

  // One extra bit keeps MOD itself representable when MOD == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   LAST_EXT = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH-1:0] LAST_W   = WIDTH'(MOD - 1);

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   next_ext;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] toggle;
  logic             wrap_nxt;
  logic             load_err_nxt;

  assign cnt_ext = {1'b0, count};

  always_comb begin
    next_ext     = cnt_ext;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (sclr) begin
      next_ext = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        next_ext = {1'b0, load_val};
      end else begin
        next_ext     = LAST_EXT;
        load_err_nxt = 1'b1;
      end
    end else if (en) begin
      // A corrupted out-of-range count recovers to 0 regardless of direction.
      if (cnt_ext >= MOD_EXT) begin
        next_ext = '0;
        wrap_nxt = 1'b1;
      end else if (up_dn == DIR_UP) begin
        if (cnt_ext == LAST_EXT) begin
          next_ext = '0;
          wrap_nxt = 1'b1;
        end else begin
          next_ext = cnt_ext + 1'b1;
        end
      end else begin
        if (cnt_ext == '0) begin
          next_ext = LAST_EXT;
          wrap_nxt = 1'b1;
        end else begin
          next_ext = cnt_ext - 1'b1;
        end
      end
    end
  end

  assign next_count = WIDTH'(next_ext);
  assign toggle     = count ^ next_count;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_bit u_tff (
        .clk  (clk),
        .rstn (rstn),
        .t    (toggle[i]),
        .q    (count[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
    end
  end

  assign tc = en & (((up_dn == DIR_UP) & (count == LAST_W)) |
                    ((up_dn == DIR_DOWN) & (count == '0)));

endmodule

// File: tb/tb_mod_updown_toggle_counter.sv
// Scoreboard bench: two counters (MOD=10 and MOD=16) share one stimulus bus.
module tb_mod_updown_toggle_counter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en, up_dn, sclr, load;
  logic [3:0] load_val;
  logic [3:0] cnt_a, cnt_b;
  logic       tc_a, tc_b, wrap_a, wrap_b, le_a, le_b;

  mod_updown_toggle_counter #(.WIDTH(4), .MOD(10)) u_dut_a (
    .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
    .load_val(load_val), .count(cnt_a), .tc(tc_a), .wrap(wrap_a), .load_err(le_a)
  );

  mod_updown_toggle_counter #(.WIDTH(4), .MOD(16)) u_dut_b (
    .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
    .load_val(load_val), .count(cnt_b), .tc(tc_b), .wrap(wrap_b), .load_err(le_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c0, c1;
    bit w0, w1, l0, l1, t0, t1;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt[2];
  int   mods[2] = '{10, 16};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference behaviour from the counter's rules, using modular arithmetic.
  function automatic void model_next(input int c, input int m, input bit e, input bit up,
                                     input bit s, input bit l, input int lv,
                                     output int n, output bit w, output bit le, output bit tc);
    tc = e && ((up && c == m - 1) || (!up && c == 0));
    n  = c;
    w  = 1'b0;
    le = 1'b0;
    if (s) begin
      n = 0;
    end else if (l) begin
      if (lv < m) n = lv;
      else begin
        n  = m - 1;
        le = 1'b1;
      end
    end else if (e) begin
      if (c >= m) begin
        n = 0;
        w = 1'b1;
      end else if (up) begin
        n = (c + 1) % m;
        w = (n == 0);
      end else begin
        n = (c + m - 1) % m;
        w = (c == 0);
      end
    end
  endfunction

  task automatic step(input bit e, input bit up, input bit s, input bit l, input int lv);
    exp_t x;
    int   n[2];
    bit   w[2], le[2], t[2];
    @(negedge clk);
    en       = e;
    up_dn    = up;
    sclr     = s;
    load     = l;
    load_val = lv[3:0];
    for (int i = 0; i < 2; i++) begin
      model_next(m_cnt[i], mods[i], e, up, s, l, lv, n[i], w[i], le[i], t[i]);
      m_cnt[i] = n[i];
    end
    x.c0 = n[0]; x.w0 = w[0]; x.l0 = le[0]; x.t0 = t[0];
    x.c1 = n[1]; x.w1 = w[1]; x.l1 = le[1]; x.t1 = t[1];
    sb_q.push_back(x);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  // Monitor: tc sampled mid-cycle after inputs settle, registered outputs after the edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        chk("tc_mod10", tc_a, x.t0);
        chk("tc_mod16", tc_b, x.t1);
        @(posedge clk);
        #1;
        chk("count_mod10", cnt_a, x.c0);
        chk("wrap_mod10", wrap_a, x.w0);
        chk("load_err_mod10", le_a, x.l0);
        chk("count_mod16", cnt_b, x.c1);
        chk("wrap_mod16", wrap_b, x.w1);
        chk("load_err_mod16", le_b, x.l1);
      end
    end
  end

  initial begin
    rstn = 1'b0; en = 1'b0; up_dn = 1'b1; sclr = 1'b0; load = 1'b0; load_val = '0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    #1;
    chk("reset_count_mod10", cnt_a, 0);
    chk("reset_wrap_mod10", wrap_a, 0);
    chk("reset_load_err_mod10", le_a, 0);
    chk("reset_count_mod16", cnt_b, 0);
    #2 rstn = 1'b1;

    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);

    step(0, 0, 0, 1, 3);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);

    step(1, 1, 0, 1, 12);
    step(0, 1, 0, 0, 0);

    step(0, 1, 0, 1, 7);
    step(1, 1, 1, 1, 2);

    step(0, 1, 0, 1, 4);
    step(1, 1, 0, 0, 0);
    drain();
    rstn = 1'b0;
    #1;
    chk("async_reset_count_mod10", cnt_a, 0);
    chk("async_reset_count_mod16", cnt_b, 0);
    chk("async_reset_wrap_mod10", wrap_a, 0);
    #1 rstn = 1'b1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    step(1, 1, 0, 0, 0);

    step(0, 1, 0, 1, 14);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 15));
    end
    drain();
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_updown_toggle_counter.md
Name: mod_updown_toggle_counter

Overview:
- Synchronous modulo-N up/down counter. It computes a per-bit toggle vector and drives a bank of toggle-flop bit cells.
- Sits directly upstream of the toggle-flop stage: this block is the toggle-enable generator plus control.
- Provides parallel load, synchronous clear, and cascade terminal-count.
- Its registered wrap pulse feeds downstream display/timer logic.

Parameters:
- WIDTH, 4, count register width in bits.
- MOD, 10, count modulus; legal count range 0..MOD-1. Legal MOD: 2 <= MOD <= 2**WIDTH; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  count enable; one step per cycle while high.
- up_dn  in  1  direction: 1 = up, 0 = down.
- sclr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational (cascade enable for the next stage).
- wrap  out  1  one-cycle registered pulse after a wrap.
- load_err  out  1  one-cycle registered pulse after an out-of-range load.

Behaviour:
- Reset: rstn low asynchronously forces count=0, wrap=0, load_err=0. The release edge is synchronised externally.
- Per-cycle priority: sclr > load > en > hold.
- sclr:
  - next count = 0; wrap=0, load_err=0 next cycle.
  - Any simultaneous load or en is ignored.
- load:
  - If load_val < MOD: next count = load_val.
  - Else: next count = MOD-1 and load_err = 1 for exactly the next cycle.
  - wrap = 0.
  - en is ignored in a load cycle.
- Counting, en=1 and up_dn=1:
  - count < MOD-1: count+1.
  - count == MOD-1: 0 and wrap=1 next cycle.
- Counting, en=1 and up_dn=0:
  - count > 0: count-1.
  - count == 0: MOD-1 and wrap=1 next cycle.
- en=0: count holds; wrap=0, load_err=0.
- Latency: count updates on the clock edge after the control is sampled. wrap and load_err appear in the same cycle as the new count value.
- tc = en & ((up_dn & count==MOD-1) | (~up_dn & count==0)). It is combinational, has no dependency on sclr/load, and is 0 when en=0.
- Direction change mid-count: takes effect on the very next enabled edge; no extra state.
- Illegal count: cannot be reached via load. If corruption puts count >= MOD, the next enabled step forces 0 in either direction, with wrap=1.
- Implementation rule:
  - next_count is computed arithmetically at WIDTH+1 bits to avoid overflow when MOD = 2**WIDTH.
  - Toggle vector t = count ^ next_count. Each bit cell toggles when t[i]=1.
  - No bit is written directly except through its cell.
- wrap and load_err are mutually exclusive. Neither is asserted in two consecutive cycles unless the triggering condition repeats.

Decomposition:
- Shared package counter_pkg:
  - Direction constants DIR_UP=1, DIR_DOWN=0.
  - Function clog2 for WIDTH checks.
  - Elaboration-time legality check for MOD vs WIDTH.
- One sub-module, tff_bit: toggle flop with inputs clk, rstn, t; output q; async active-low reset to 0.
  - Instantiated WIDTH times via generate.
  - sclr/load are folded into t (t = q ^ desired), so the cell stays a pure toggle flop.

Test Plan:
- Reset, then en=1, up_dn=1 for 12 cycles (WIDTH=4, MOD=10) -> count 1,2,...,9,0,1,2. wrap high only in the cycle count shows 0 after 9. tc high only while count==9.
- load=1, load_val=3, then en=1, up_dn=0 for 5 cycles -> count 3,2,1,0,9,8. tc high while count==0. wrap pulses with the first 9.
- load_val=12 with load=1 -> count=9, load_err=1 for one cycle, wrap=0. A simultaneous en=1 is ignored.
- sclr=1, load=1, en=1 together at count=7 -> count=0 next cycle; no wrap, no load_err.
- Assert rstn low mid-count at count=5 between clock edges -> count=0 immediately, before the next edge. Count resumes 1 on the first enabled edge after release.
- MOD=16, WIDTH=4, up from 14 -> 15, 0 with wrap. No width overflow. tc high at 15 with en=1, low at 15 with en=0.
